// File: rtl/line_follower_nch_if.sv
// -----------------------------------------------------------------------------
// line_follower_nch_if
// Bundle between the ADC controller (sensor samples), the node-action source,
// and the PWM/motor driver for the N-channel line follower.
//
// Handshake: sample_valid is a one-cycle strobe qualifying sens in the same
// cycle. There is no ready/back-pressure: the follower always accepts, and a
// newer strobe simply overwrites a sample still waiting in its pipeline.
//
// Signals:
//   sens         N_SENS*SW  samples, channel i at [i*SW +: SW], 0 = leftmost
//   sample_valid 1          sample strobe
//   direction    3          node action: 0 straight, 1 left, 2 right,
//                           3 reverse, 4-7 stop
//   fault        1          level, forces FAULT while high
//   m1, m2       SW         left / right motor duty
//   m1_forward   1          left motor direction (1 = forward)
//   m2_forward   1          right motor direction (1 = forward)
//   node_pulse   1          one-cycle pulse on node confirm
//   node_cnt     8          confirmed node count (wraps)
//   busy         1          in TURN or REVERSE
//   lost         1          in LOST
//   state_dbg    3          current FSM state encoding
// -----------------------------------------------------------------------------
interface line_follower_nch_if #(
  parameter int N_SENS = 3,
  parameter int SW     = 12
);
  logic [N_SENS*SW-1:0] sens;
  logic                 sample_valid;
  logic [2:0]           direction;
  logic                 fault;
  logic [SW-1:0]        m1;
  logic [SW-1:0]        m2;
  logic                 m1_forward;
  logic                 m2_forward;
  logic                 node_pulse;
  logic [7:0]           node_cnt;
  logic                 busy;
  logic                 lost;
  logic [2:0]           state_dbg;

  // Sensor/command side.
  modport master (
    output sens, sample_valid, direction, fault,
    input  m1, m2, m1_forward, m2_forward, node_pulse, node_cnt, busy, lost,
           state_dbg
  );

  // Follower side.
  modport slave (
    input  sens, sample_valid, direction, fault,
    output m1, m2, m1_forward, m2_forward, node_pulse, node_cnt, busy, lost,
           state_dbg
  );
endinterface

// File: rtl/line_follower_nch.sv
// -----------------------------------------------------------------------------
// line_follower_nch
// N-channel black-line follower. Thresholds the sensor samples into a bitmap,
// steers proportionally to the line's offset from centre, and runs node
// manoeuvres (straight/left/right turn, reverse spin, stop) with debounce,
// a post-manoeuvre lockout, a node counter, and LOST/FAULT states.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  line_follower_nch_if.slave (samples/commands in, motor drive out)
//
// Pipeline: stage 1 registers the bitmap on sample_valid, stage 2 (the FSM)
// acts on it the next cycle, so outputs move two edges after the strobe.
// -----------------------------------------------------------------------------
module line_follower_nch #(
  parameter int N_SENS   = 3,
  parameter int SW       = 12,
  parameter int THRESH   = 110,
  parameter int BASE     = 1200,
  parameter int KP       = 200,
  parameter int TURN     = 1500,
  parameter int SPIN     = 1000,
  parameter int SEARCH   = 500,
  parameter int MAX_DUTY = 4095,
  parameter int NODE_DEB = 2,
  parameter int TURN_CYC = 1000000,
  parameter int REV_MIN  = 1000000,
  parameter int LOCKOUT  = 4000000,
  parameter int CW       = 27
) (
  input logic                clk,
  input logic                rst,
  line_follower_nch_if.slave bus
);

  typedef enum logic [2:0] {
    S_FOLLOW  = 3'd0,
    S_LOST    = 3'd1,
    S_TURN    = 3'd2,
    S_REVERSE = 3'd3,
    S_STOP    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t              state_q;
  logic [N_SENS-1:0]   bm_d, bm_q;
  logic                vld_q;
  logic [7:0]          deb_q;
  logic [CW-1:0]       tc_q;
  logic [CW-1:0]       lock_q;
  logic signed [4:0]   last_off_q;
  logic [SW-1:0]       m1_q, m2_q;
  logic                m1f_q, m2f_q;
  logic                pulse_q;
  logic [7:0]          cnt_q;

  int                  lm, rm, off;
  logic [SW-1:0]       fol_m1, fol_m2;
  logic [SW-1:0]       lost_m1, lost_m2;
  state_t              act_state;
  logic [SW-1:0]       act_m1, act_m2;
  logic                act_m1f, act_m2f;
  logic                all_on;

  // Clamp a signed duty request into 0..MAX_DUTY. int is wide enough that
  // BASE +/- offset*KP cannot wrap for any legal parameter set.
  function automatic logic [SW-1:0] sat(input int v);
    if (v < 0)        return '0;
    if (v > MAX_DUTY) return SW'(MAX_DUTY);
    return SW'(v);
  endfunction

  // Stage 1: threshold every channel; equal to THRESH counts as on-line.
  always_comb begin
    bm_d = '0;
    for (int i = 0; i < N_SENS; i++)
      bm_d[i] = (bus.sens[i*SW +: SW] >= SW'(THRESH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bm_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.sample_valid;
      if (bus.sample_valid) bm_q <= bm_d;
    end
  end

  // Outermost on-line channels give the line position; their sum minus
  // (N_SENS-1) is zero when the line is centred.
  always_comb begin
    lm = 0;
    rm = 0;
    for (int i = N_SENS - 1; i >= 0; i--) if (bm_q[i]) lm = i;
    for (int i = 0; i < N_SENS; i++)      if (bm_q[i]) rm = i;
    off    = lm + rm - (N_SENS - 1);
    fol_m1 = sat(BASE + off * KP);
    fol_m2 = sat(BASE - off * KP);
    all_on = &bm_q;
  end

  // Lost-line recovery: swing toward the side the line was last seen on.
  always_comb begin
    lost_m1 = SW'(SEARCH);
    lost_m2 = SW'(SEARCH);
    if (last_off_q[4]) begin
      lost_m1 = '0;
      lost_m2 = SW'(TURN);
    end else if (last_off_q != '0) begin
      lost_m1 = SW'(TURN);
      lost_m2 = '0;
    end
  end

  // Node action selected by the direction input; outputs are loaded on entry
  // and held for the whole manoeuvre.
  always_comb begin
    act_state = S_STOP;
    act_m1    = '0;
    act_m2    = '0;
    act_m1f   = 1'b0;
    act_m2f   = 1'b0;
    case (bus.direction)
      3'd0: begin
        act_state = S_TURN; act_m1 = SW'(BASE); act_m2 = SW'(BASE);
        act_m1f = 1'b1; act_m2f = 1'b1;
      end
      3'd1: begin
        act_state = S_TURN; act_m2 = SW'(TURN);
        act_m1f = 1'b1; act_m2f = 1'b1;
      end
      3'd2: begin
        act_state = S_TURN; act_m1 = SW'(TURN);
        act_m1f = 1'b1; act_m2f = 1'b1;
      end
      3'd3: begin
        act_state = S_REVERSE; act_m1 = SW'(SPIN); act_m2 = SW'(SPIN);
        act_m1f = 1'b1; act_m2f = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage 2: control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FOLLOW;
      deb_q      <= '0;
      tc_q       <= '0;
      lock_q     <= '0;
      last_off_q <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      m1f_q      <= 1'b0;
      m2f_q      <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (lock_q != '0) lock_q <= lock_q - 1'b1;

      if (bus.fault) begin
        state_q <= S_FAULT;
        m1_q    <= '0;
        m2_q    <= '0;
        m1f_q   <= 1'b0;
        m2f_q   <= 1'b0;
        tc_q    <= '0;
        deb_q   <= '0;
        lock_q  <= '0;
      end else begin
        case (state_q)
          S_FOLLOW: if (vld_q) begin
            if (bm_q == '0) begin
              state_q <= S_LOST;
              deb_q   <= '0;
              m1_q    <= lost_m1;
              m2_q    <= lost_m2;
              m1f_q   <= 1'b1;
              m2f_q   <= 1'b1;
            end else if (all_on && lock_q == '0 &&
                         deb_q == 8'(NODE_DEB - 1)) begin
              pulse_q <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              deb_q   <= '0;
              tc_q    <= '0;
              state_q <= act_state;
              m1_q    <= act_m1;
              m2_q    <= act_m2;
              m1f_q   <= act_m1f;
              m2f_q   <= act_m2f;
            end else begin
              deb_q      <= (all_on && lock_q == '0) ? deb_q + 1'b1 : '0;
              last_off_q <= 5'(off);
              m1_q       <= fol_m1;
              m2_q       <= fol_m2;
              m1f_q      <= 1'b1;
              m2f_q      <= 1'b1;
            end
          end
          S_LOST: if (vld_q && bm_q != '0) begin
            state_q    <= S_FOLLOW;
            deb_q      <= '0;
            last_off_q <= 5'(off);
            m1_q       <= fol_m1;
            m2_q       <= fol_m2;
            m1f_q      <= 1'b1;
            m2f_q      <= 1'b1;
          end
          S_TURN: begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == CW'(TURN_CYC - 1)) begin
              // Leave the node heading straight until the next sample.
              state_q    <= S_FOLLOW;
              tc_q       <= '0;
              lock_q     <= CW'(LOCKOUT);
              last_off_q <= '0;
              m1_q       <= SW'(BASE);
              m2_q       <= SW'(BASE);
              m1f_q      <= 1'b1;
              m2f_q      <= 1'b1;
            end
          end
          S_REVERSE: begin
            // Saturate at REV_MIN so a long spin cannot wrap the counter.
            if (tc_q != CW'(REV_MIN)) tc_q <= tc_q + 1'b1;
            if (vld_q && bm_q[N_SENS/2] && tc_q >= CW'(REV_MIN)) begin
              state_q    <= S_FOLLOW;
              tc_q       <= '0;
              deb_q      <= '0;
              lock_q     <= CW'(LOCKOUT);
              last_off_q <= 5'(off);
              m1_q       <= fol_m1;
              m2_q       <= fol_m2;
              m1f_q      <= 1'b1;
              m2f_q      <= 1'b1;
            end
          end
          S_STOP: if (vld_q && act_state != S_STOP) begin
            tc_q    <= '0;
            state_q <= act_state;
            m1_q    <= act_m1;
            m2_q    <= act_m2;
            m1f_q   <= act_m1f;
            m2f_q   <= act_m2f;
          end
          S_FAULT: begin
            state_q    <= S_FOLLOW;
            last_off_q <= '0;
          end
          default: state_q <= S_FOLLOW;
        endcase
      end
    end
  end

  assign bus.m1         = m1_q;
  assign bus.m2         = m2_q;
  assign bus.m1_forward = m1f_q;
  assign bus.m2_forward = m2f_q;
  assign bus.node_pulse = pulse_q;
  assign bus.node_cnt   = cnt_q;
  assign bus.busy       = (state_q == S_TURN) || (state_q == S_REVERSE);
  assign bus.lost       = (state_q == S_LOST);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_line_follower_nch.sv
// -----------------------------------------------------------------------------
// tb_line_follower_nch
// Directed bench for line_follower_nch (N_SENS = 3) with short manoeuvre
// timers: TURN_CYC = 20, LOCKOUT = 50, REV_MIN = 30.
// -----------------------------------------------------------------------------
module tb_line_follower_nch;
  localparam int N_SENS = 3;
  localparam int SW     = 12;

  localparam logic [2:0] ST_FOLLOW = 3'd0;
  localparam logic [2:0] ST_FAULT  = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  line_follower_nch_if #(.N_SENS(N_SENS), .SW(SW)) bus ();

  line_follower_nch #(
    .N_SENS(N_SENS), .SW(SW), .TURN_CYC(20), .REV_MIN(30), .LOCKOUT(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_raw(input int v0, input int v1, input int v2,
                          input logic [2:0] dir);
    @(negedge clk);
    bus.sens         = {12'(v2), 12'(v1), 12'(v0)};
    bus.direction    = dir;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  // Bit i of b is channel i (bit 0 = leftmost).
  task automatic send_b(input logic [2:0] b, input logic [2:0] dir);
    send_raw(b[0] ? 200 : 50, b[1] ? 200 : 50, b[2] ? 200 : 50, dir);
  endtask

  // Send and wait until the FSM has acted on the sample.
  task automatic apply_b(input logic [2:0] b, input logic [2:0] dir);
    send_b(b, dir);
    @(negedge clk);
  endtask

  task automatic check_motors(input string tag, input int e1, input int e2,
                              input logic f1, input logic f2);
    check({tag, ".m1"}, 32'(bus.m1), 32'(e1));
    check({tag, ".m2"}, 32'(bus.m2), 32'(e2));
    check({tag, ".m1f"}, 32'(bus.m1_forward), 32'(f1));
    check({tag, ".m2f"}, 32'(bus.m2_forward), 32'(f2));
  endtask

  int turn_cycles;
  int pulses;
  int bad_duty;

  initial begin
    rst = 1'b1;
    bus.sens = '0;
    bus.sample_valid = 1'b0;
    bus.direction = 3'd0;
    bus.fault = 1'b0;
    wait_n(3);

    // Reset state
    check_motors("reset", 0, 0, 1'b0, 1'b0);
    check("reset.pulse", 32'(bus.node_pulse), 0);
    check("reset.cnt", 32'(bus.node_cnt), 0);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.lost", 32'(bus.lost), 0);
    check("reset.state", 32'(bus.state_dbg), 32'(ST_FOLLOW));
    rst = 1'b0;
    wait_n(2);

    // Proportional following
    apply_b(3'b010, 3'd0);
    check_motors("follow_c", 1200, 1200, 1'b1, 1'b1);
    apply_b(3'b110, 3'd0);
    check_motors("follow_cr", 1400, 1000, 1'b1, 1'b1);
    apply_b(3'b100, 3'd0);
    check_motors("follow_r", 1600, 800, 1'b1, 1'b1);
    // Threshold boundary: 110 is on, 109 is off -> centre only.
    send_raw(109, 110, 50, 3'd0);
    @(negedge clk);
    check_motors("thresh_edge", 1200, 1200, 1'b1, 1'b1);

    // Lost line, last seen on the left
    apply_b(3'b001, 3'd0);
    check_motors("follow_l", 800, 1600, 1'b1, 1'b1);
    apply_b(3'b000, 3'd0);
    check_motors("lost", 0, 1500, 1'b1, 1'b1);
    check("lost.flag", 32'(bus.lost), 1);
    apply_b(3'b010, 3'd0);
    check_motors("refind", 1200, 1200, 1'b1, 1'b1);
    check("refind.lost", 32'(bus.lost), 0);

    // Node with left turn
    apply_b(3'b111, 3'd1);
    check("deb1.pulse", 32'(bus.node_pulse), 0);
    check("deb1.busy", 32'(bus.busy), 0);
    apply_b(3'b111, 3'd1);
    check("node1.cnt", 32'(bus.node_cnt), 1);
    turn_cycles = 0;
    pulses = 0;
    bad_duty = 0;
    while (bus.busy && turn_cycles < 100) begin
      turn_cycles++;
      if (bus.node_pulse) pulses++;
      if (bus.m1 != 12'd0 || bus.m2 != 12'd1500) bad_duty++;
      @(negedge clk);
    end
    check("turn.cycles", 32'(turn_cycles), 20);
    check("turn.pulses", 32'(pulses), 1);
    check("turn.duty", 32'(bad_duty), 0);
    check_motors("turn_exit", 1200, 1200, 1'b1, 1'b1);
    // Within lockout: all-on samples must not confirm a node.
    apply_b(3'b111, 3'd1);
    apply_b(3'b111, 3'd1);
    check("lockout.pulse", 32'(bus.node_pulse), 0);
    check("lockout.cnt", 32'(bus.node_cnt), 1);
    check("lockout.busy", 32'(bus.busy), 0);
    wait_n(60);

    // Reverse spin
    apply_b(3'b111, 3'd3);
    apply_b(3'b111, 3'd3);
    check("rev.pulse", 32'(bus.node_pulse), 1);
    check("rev.cnt", 32'(bus.node_cnt), 2);
    check_motors("rev", 1000, 1000, 1'b1, 1'b0);
    wait_n(5);
    apply_b(3'b010, 3'd0);
    check("rev_early.busy", 32'(bus.busy), 1);
    check_motors("rev_early", 1000, 1000, 1'b1, 1'b0);
    wait_n(30);
    apply_b(3'b010, 3'd0);
    check("rev_exit.busy", 32'(bus.busy), 0);
    check_motors("rev_exit", 1200, 1200, 1'b1, 1'b1);
    wait_n(60);

    // Fault mid-turn (right)
    apply_b(3'b111, 3'd2);
    apply_b(3'b111, 3'd2);
    check_motors("turn_r", 1500, 0, 1'b1, 1'b1);
    check("turn_r.cnt", 32'(bus.node_cnt), 3);
    wait_n(5);
    bus.fault = 1'b1;
    @(negedge clk);
    check_motors("fault", 0, 0, 1'b0, 1'b0);
    check("fault.busy", 32'(bus.busy), 0);
    check("fault.state", 32'(bus.state_dbg), 32'(ST_FAULT));
    bus.fault = 1'b0;
    @(negedge clk);
    check("fault_rel.state", 32'(bus.state_dbg), 32'(ST_FOLLOW));
    check("fault_rel.cnt", 32'(bus.node_cnt), 3);
    // Lockout is clear, so a node confirms straight away: stop.
    apply_b(3'b111, 3'd4);
    check_motors("post_fault", 1200, 1200, 1'b1, 1'b1);
    apply_b(3'b111, 3'd4);
    check("stop.pulse", 32'(bus.node_pulse), 1);
    check("stop.cnt", 32'(bus.node_cnt), 4);
    check("stop.state", 32'(bus.state_dbg), 32'(ST_STOP));
    check_motors("stop", 0, 0, 1'b0, 1'b0);
    apply_b(3'b111, 3'd5);
    check("stop_reread.pulse", 32'(bus.node_pulse), 0);
    check("stop_reread.cnt", 32'(bus.node_cnt), 4);
    check("stop_reread.state", 32'(bus.state_dbg), 32'(ST_STOP));

    // Counter wrap: 252 more nodes takes the count from 4 through 255 to 0.
    for (int i = 0; i < 252; i++) begin
      @(negedge clk);
      bus.fault = 1'b1;
      @(negedge clk);
      bus.fault = 1'b0;
      send_b(3'b111, 3'd4);
      send_b(3'b111, 3'd4);
      @(negedge clk);
      if (i == 250) check("cnt_255", 32'(bus.node_cnt), 255);
    end
    check("cnt_wrap", 32'(bus.node_cnt), 0);

    // STOP re-read into reverse, then asynchronous reset mid-spin
    apply_b(3'b000, 3'd3);
    check("stop2rev.busy", 32'(bus.busy), 1);
    check("stop2rev.pulse", 32'(bus.node_pulse), 0);
    check("stop2rev.cnt", 32'(bus.node_cnt), 0);
    check_motors("stop2rev", 1000, 1000, 1'b1, 1'b0);
    wait_n(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_motors("async_rst", 0, 0, 1'b0, 1'b0);
    check("async_rst.busy", 32'(bus.busy), 0);
    check("async_rst.state", 32'(bus.state_dbg), 32'(ST_FOLLOW));
    @(negedge clk);
    rst = 1'b0;
    wait_n(2);
    check("post_rst.cnt", 32'(bus.node_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_follower_nch.md
# line_follower_nch

Parametrised black-line follower controller: thresholds N reflectance channels, derives a steering offset, drives left/right motor duty and direction, and executes node manoeuvres (straight, left, right, reverse-spin, stop). It sits between the ADC controller, which supplies the sensor samples and the valid strobe, and the PWM/motor driver, which consumes the duty and direction outputs. It generalises the fixed 3-sensor follower to N sensors with:
- proportional steering,
- node debounce,
- a post-node lockout window,
- a node counter,
- explicit fault and lost-line states.

## Interface
Parameters:
- N_SENS, 3: sensor channel count (3..8); index 0 = leftmost
- SW, 12: sensor and duty width
- THRESH, 110: channel is "on line" when sample >= THRESH
- BASE, 1200: straight-line duty
- KP, 200: duty change per unit offset
- TURN, 1500: node left/right outer-wheel duty
- SPIN, 1000: reverse-spin duty
- SEARCH, 500: lost-line duty when no prior offset
- MAX_DUTY, 4095: upper saturation for m1/m2
- NODE_DEB, 2: consecutive all-on samples needed to confirm a node
- TURN_CYC, 1000000: clk cycles the sensors are ignored during a node manoeuvre
- REV_MIN, 1000000: minimum spin cycles before reverse may exit
- LOCKOUT, 4000000: cycles after manoeuvre end during which no node can be confirmed
- CW, 27: width of the cycle counters

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sens  in  N_SENS*SW  samples; channel i at [i*SW +: SW]
- sample_valid  in  1  one-cycle strobe; sens is valid this cycle
- direction  in  3  node action: 0 straight, 1 left, 2 right, 3 reverse, 4-7 stop
- fault  in  1  level; forces FAULT while high
- m1  out  SW  left motor duty
- m2  out  SW  right motor duty
- m1_forward  out  1  left motor direction (1 = forward)
- m2_forward  out  1  right motor direction (1 = forward)
- node_pulse  out  1  one-cycle pulse on node confirm
- node_cnt  out  8  confirmed node count, wraps 255->0
- busy  out  1  high in TURN or REVERSE
- lost  out  1  high in LOST

## Operation
- Stage 1: on sample_valid, register bitmap b[i] = (sens_i >= THRESH) and raise an internal valid flag.
- Stage 2: the FSM and outputs update on the flagged sample.
- lm = lowest set index of b; rm = highest set index.
- offset = (lm + rm) - (N_SENS-1), signed; range -(N_SENS-1)..+(N_SENS-1).
- Follow command: m1 = BASE + offset*KP, m2 = BASE - offset*KP.
  - Computed signed at SW+5 bits; saturate to 0..MAX_DUTY.
  - Both directions forward.
  - last_off <= offset on every FOLLOW update.
- States: FOLLOW, LOST, TURN, REVERSE, STOP, FAULT.
- FOLLOW:
  - b == 0 -> LOST.
  - All bits set and lockout == 0: increment deb. When deb reaches NODE_DEB:
    - node_pulse, node_cnt++, deb <= 0.
    - direction 0..2 -> TURN with the action latched.
    - direction 3 -> REVERSE.
    - direction 4..7 -> STOP.
  - All bits set and lockout != 0: apply the follow command (offset 0).
  - Any other valid sample clears deb.
- LOST:
  - last_off < 0: m1 = 0, m2 = TURN.
  - last_off > 0: m1 = TURN, m2 = 0.
  - last_off == 0: both SEARCH.
  - Both motors forward in all cases.
  - Any valid sample with b != 0 -> FOLLOW, that sample is applied; deb restarts at 0.
- TURN (the cycle counter tc counts every clk):
  - Straight: both BASE.
  - Left: m1 = 0, m2 = TURN.
  - Right: m1 = TURN, m2 = 0.
  - Sensors ignored.
  - At tc == TURN_CYC-1 -> FOLLOW; lockout loads LOCKOUT; last_off <= 0.
- REVERSE:
  - m1 = m2 = SPIN; m1_forward = 1, m2_forward = 0.
  - Exit to FOLLOW on the first valid sample with b[N_SENS/2] = 1 and tc >= REV_MIN; lockout loads LOCKOUT.
- STOP:
  - Duty 0, directions 0.
  - Each valid sample re-reads direction: 0..2 -> TURN, 3 -> REVERSE, else remain in STOP.
  - Re-reads do not pulse or count.
- FAULT:
  - Duty 0, directions 0; tc, deb and lockout are held at 0.
  - Entered from any state while fault = 1, with priority over all other events.
  - On deassert -> FOLLOW; last_off <= 0.
- lockout decrements every clk while non-zero in any state except FAULT.

## Timing
- Reset (async assert) values:
  - m1 = m2 = 0; m1_forward = m2_forward = 0.
  - node_pulse = 0, node_cnt = 0, busy = 0, lost = 0.
  - State FOLLOW; deb, tc, lockout, last_off and the valid flag all 0.
- Reset release is synchronous to clk.
- Latency: sample_valid at cycle t -> outputs change at the clk edge ending cycle t+1 (2 registers).
- node_pulse is high exactly one cycle, coincident with the state change into TURN/REVERSE/STOP.
- TURN occupies exactly TURN_CYC cycles.
- The fault level is sampled every clk: outputs are zero one cycle after fault rises.
- A sample_valid that arrives while the pipeline holds a sample overwrites the bitmap; no queueing.

## Test plan
- Defaults, b = 010 -> m1 = m2 = 1200 forward; b = 011 (right + centre) -> m1 = 1400, m2 = 1000; b = 001 -> m1 = 1600, m2 = 800.
- TURN_CYC = 20, LOCKOUT = 50: two valid 111 samples, direction = 1 -> node_pulse once, node_cnt = 1, m1 = 0, m2 = 1500 for 20 cycles; further 111 samples within 50 cycles give no pulse.
- b = 100 then 000 -> LOST with m1 = 0, m2 = 1500, lost = 1; then b = 010 -> FOLLOW at 1200/1200.
- REV_MIN = 30, direction = 3: b = 010 at cycle 10 -> no exit; b = 010 after cycle 30 -> FOLLOW. During the spin, m1 = m2 = 1000, m2_forward = 0.
- fault pulsed mid-TURN -> outputs 0 next cycle; on release, FOLLOW with lockout 0; node_cnt unchanged.
- 256 confirmed nodes -> node_cnt wraps to 0; rst asserted mid-REVERSE -> all outputs 0 immediately.
